clock_divider_prog: RTL and testbench
=====================================

# clock_divider_prog

Parametrised programmable clock divider producing a divided clock-enable waveform and a one-cycle period tick from the system clock. It replaces the fixed 4-bit counter/comparator/toggle chain with a single registered counter of configurable width. It adds square-wave and pulse output modes, glitch-free ratio changes at period boundaries, and a synchronous phase restart. It sits between the board clock and any slower timing consumers, such as display scanners, debouncers and LED blinkers.

## Interface
- WIDTH, 16, width of divide ratio and internal counter (>= 2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low holds block idle
- div  in  WIDTH  requested divide ratio D; period P = max(D,2) clk cycles
- mode  in  1  0 = square wave, 1 = single-cycle pulse per period
- restart  in  1  synchronous phase realign, active high
- clkout  out  1  divided waveform, registered
- tick  out  1  one-cycle pulse on the first cycle of each output period, registered

## Operation
- State:
  - cnt[WIDTH-1:0], phase within the current period.
  - cur_div[WIDTH-1:0], shadowed ratio.
  - cur_mode, shadowed mode.
- Derived values:
  - P = (cur_div < 2) ? 2 : cur_div.
  - H = cur_mode ? 1 : P >> 1 (floor).
  - Unsigned compares only. No arithmetic wider than WIDTH; P-1 never underflows.
- Idle (en=0, highest priority), each edge:
  - cnt <= 0, clkout <= 0, tick <= 0.
  - cur_div <= div, cur_mode <= mode. Shadows track inputs continuously.
- Restart (en=1, restart=1), each edge:
  - cur_div <= div, cur_mode <= mode.
  - clkout <= 1, tick <= 1, cnt <= 1.
  - The next period begins using the new div and mode. When the new P=2, cnt=1 is already the last phase.
- Run (en=1, restart=0), each edge:
  - clkout <= (cnt < H).
  - tick <= (cnt == 0).
  - If cnt == P-1: cnt <= 0, cur_div <= div, cur_mode <= mode. This is a period boundary.
  - Else: cnt <= cnt+1.
- Glitch-free ratio updates:
  - div and mode changes during run take effect only at the next period boundary.
  - No truncated or stretched high phase is ever produced.
- Disable mid-period truncates immediately. clkout drops to 0 on the next edge; no partial tick.
- Odd P in square mode: high floor(P/2) cycles, low ceil(P/2) cycles.
- div=0 and div=1 behave exactly as div=2.
- Maximum ratio is 2^WIDTH-1.

## Timing
- Reset: clkout=0, tick=0, cnt=0, cur_div=0, cur_mode=0, asynchronously on rst_n fall. Release is sampled on the next clk edge.
- Start latency: on the first edge with en=1 (from idle), clkout=1 and tick=1 become visible after that edge, using the div/mode present on the preceding idle edge.
- Steady state:
  - clkout period = P cycles exactly.
  - tick asserts for 1 cycle, coincident with the first clkout-high cycle of each period.
- Ratio change: a new div sampled on the boundary edge (cnt==P-1) governs the period whose tick appears one edge later.
- restart and en high together: the restart rule applies. restart with en low is ignored.
- Reset asserted mid-period: outputs go low immediately, with no clk edge required.

## Test plan
- Reset and idle:
  - Stimulus: rst_n=0, then released with en=0, div=5 for 10 cycles.
  - Required: clkout=0 and tick=0 throughout.
- Square mode, div=5:
  - Stimulus: en rises.
  - Required: clkout high 2 cycles, low 3 cycles, repeating. tick every 5 cycles, aligned to the clkout rise. First high appears one edge after en is sampled.
- Degenerate ratios:
  - Stimulus: div=0, then div=1, then div=2, square mode.
  - Required: all three produce an alternating 1,0 clkout with tick every 2 cycles.
- Glitch-free change:
  - Stimulus: run div=8, change div to 3 at cnt=2.
  - Required: current period completes 4 high + 4 low, then 1 high + 2 low periods follow. No short pulse.
- Pulse mode and restart:
  - Stimulus: mode=1, div=6; pulse restart at cnt=3.
  - Required: clkout equals tick, 1 cycle high per 6. restart yields a pulse on the next edge, and the following pulse comes 6 cycles later.
- Mid-operation disable and reset:
  - Stimulus 1: drop en during the high phase at div=10.
  - Required: clkout=0 next edge; on re-enable, a full fresh period.
  - Stimulus 2: assert rst_n low between edges.
  - Required: outputs 0 immediately.
- WIDTH sweep:
  - Stimulus: WIDTH=4, div=15.
  - Required: period 15, high 7, no counter overflow.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Programmable clock divider: square-wave or pulse output plus a period tick.
// Ratio and mode are shadowed and only reloaded at period boundaries, on restart or while idle.
module clock_divider_prog #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] div,
   input  logic             mode,
   input  logic             restart,
   output logic             clkout,
   output logic             tick
);

   logic [WIDTH-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0] cur_div_q, cur_div_d;
   logic             cur_mode_q, cur_mode_d;
   logic             clkout_q,  clkout_d;
   logic             tick_q,    tick_d;

   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] half;
   logic             last_phase;

   // Ratios below 2 collapse to 2, so period-1 never underflows.
   assign period     = (cur_div_q < WIDTH'(2)) ? WIDTH'(2) : cur_div_q;
   assign half       = cur_mode_q ? WIDTH'(1) : (period >> 1);
   assign last_phase = (cnt_q == (period - WIDTH'(1)));

   always_comb begin
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      cur_mode_d = cur_mode_q;
      clkout_d   = clkout_q;
      tick_d     = tick_q;

      if (!en) begin
         cnt_d      = '0;
         clkout_d   = 1'b0;
         tick_d     = 1'b0;
         cur_div_d  = div;
         cur_mode_d = mode;
      end else if (restart) begin
         // Phase 0 is emitted on this edge, so the counter resumes at 1.
         cnt_d      = WIDTH'(1);
         clkout_d   = 1'b1;
         tick_d     = 1'b1;
         cur_div_d  = div;
         cur_mode_d = mode;
      end else begin
         clkout_d = (cnt_q < half);
         tick_d   = (cnt_q == '0);
         if (last_phase) begin
            cnt_d      = '0;
            cur_div_d  = div;
            cur_mode_d = mode;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         cur_div_q  <= '0;
         cur_mode_q <= 1'b0;
         clkout_q   <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         cur_mode_q <= cur_mode_d;
         clkout_q   <= clkout_d;
         tick_q     <= tick_d;
      end
   end

   assign clkout = clkout_q;
   assign tick   = tick_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: expected clkout/tick sequences are written out per edge.
module tb_clock_divider_prog;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en, mode, restart;
   logic [15:0] div;
   logic        clkout, tick;

   logic        en4;
   logic [3:0]  div4;
   logic        clkout4, tick4;

   int vectors_applied = 0;
   int miscompares     = 0;

   always #5 clk = ~clk;

   clock_divider_prog #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .div(div), .mode(mode),
      .restart(restart), .clkout(clkout), .tick(tick)
   );

   clock_divider_prog #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .div(div4), .mode(1'b0),
      .restart(1'b0), .clkout(clkout4), .tick(tick4)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One character per edge; each output is sampled 1 time unit after the rising edge.
   task automatic expect_seq(input string tag, input bit narrow, input string cpat, input string tpat);
      for (int i = 0; i < cpat.len(); i++) begin
         @(posedge clk);
         #1;
         if (narrow) begin
            check_val($sformatf("%s[%0d].clkout", tag, i), {31'd0, clkout4}, {31'd0, cpat[i] == 8'h31});
            check_val($sformatf("%s[%0d].tick",   tag, i), {31'd0, tick4},   {31'd0, tpat[i] == 8'h31});
         end else begin
            check_val($sformatf("%s[%0d].clkout", tag, i), {31'd0, clkout},  {31'd0, cpat[i] == 8'h31});
            check_val($sformatf("%s[%0d].tick",   tag, i), {31'd0, tick},    {31'd0, tpat[i] == 8'h31});
         end
      end
   endtask

   task automatic go_idle(input logic [15:0] d, input logic m);
      en   = 1'b0;
      div  = d;
      mode = m;
      expect_seq("idle", 1'b0, "0", "0");
      en = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; div = 16'd5; mode = 1'b0; restart = 1'b0;
      en4 = 1'b0; div4 = 4'd15;

      // Reset held, then idle with restart toggling (ignored while disabled)
      repeat (2) @(posedge clk);
      #1;
      check_val("rst.clkout", {31'd0, clkout}, 32'd0);
      check_val("rst.tick",   {31'd0, tick},   32'd0);
      #3 rst_n = 1'b1;
      expect_seq("idle5", 1'b0, "00000", "00000");
      restart = 1'b1;
      expect_seq("idle_rst", 1'b0, "00000", "00000");
      restart = 1'b0;

      // Square mode, div=5: 2 high, 3 low
      en = 1'b1;
      expect_seq("sq5", 1'b0, "110001100011000", "100001000010000");

      // Degenerate ratios 0, 1, 2
      go_idle(16'd0, 1'b0);
      expect_seq("div0", 1'b0, "101010", "101010");
      div = 16'd1;
      expect_seq("div1", 1'b0, "101010", "101010");
      div = 16'd2;
      expect_seq("div2", 1'b0, "101010", "101010");

      // Glitch-free change 8 -> 3 while cnt=2
      go_idle(16'd8, 1'b0);
      expect_seq("g8a", 1'b0, "11", "10");
      div = 16'd3;
      expect_seq("g8b", 1'b0, "110000100100100", "000000100100100");

      // Pulse mode div=6 with restart at cnt=3
      go_idle(16'd6, 1'b1);
      expect_seq("pls", 1'b0, "100", "100");
      restart = 1'b1;
      expect_seq("pls_rst", 1'b0, "1", "1");
      restart = 1'b0;
      expect_seq("pls_after", 1'b0, "0000010000010", "0000010000010");

      // Disable during high phase at div=10, then a fresh period
      go_idle(16'd10, 1'b0);
      expect_seq("d10a", 1'b0, "11", "10");
      en = 1'b0;
      expect_seq("d10off", 1'b0, "0", "0");
      en = 1'b1;
      expect_seq("d10b", 1'b0, "11111000001", "10000000001");

      // Asynchronous reset between edges while clkout is high
      #2 rst_n = 1'b0;
      #1;
      check_val("arst.clkout", {31'd0, clkout}, 32'd0);
      check_val("arst.tick",   {31'd0, tick},   32'd0);
      #2 rst_n = 1'b1;
      // Shadow ratio restarts at 0 (P=2) for the first period, then picks up div=10
      expect_seq("post_rst", 1'b0, "101111100000", "101000000000");

      // WIDTH=4, div=15: period 15, high 7
      en4 = 1'b1;
      expect_seq("w4", 1'b1, "111111100000000111111100000000", "100000000000000100000000000000");

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
